// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   rst_state_e : 2-bit FSM state encoding
//   cnt_width() : width of the shared stretch/gap counter
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT     = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_RELEASE    = 2'd2,
    ST_DONE       = 2'd3
  } rst_state_e;

  // The counter must hold the value max(stretch, gap) without wrapping.
  function automatic int cnt_width(input int stretch, input int gap);
    int m;
    m = (stretch > gap) ? stretch : gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases synchronously.
//   clk     : clock
//   reset   : async active-high reset in
//   reset_s : synchronized reset, low after the STAGES-th edge with reset low
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic reset_s
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign reset_s = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all domain resets, waits for supplies ready, then
// releases rst_out[0..NUM_OUT-1] one by one, GAP_CYCLES apart.
//   clk          : clock
//   reset        : async active-high reset
//   ready_in     : async supplies/PLL ready qualifier
//   soft_rst_req : sync single-cycle request for a full re-sequence
//   rst_out      : per-domain active-high resets (flopped)
//   done         : all rst_out released (flopped)
//   busy         : FSM not in DONE (flopped)
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_OUT        = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready_in,
  input  logic               soft_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               done,
  output logic               busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || NUM_OUT < 1 || NUM_OUT > 16 ||
      STRETCH_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_param
    $error("rst_sequencer: illegal parameter value");
  end

  localparam int CW = cnt_width(STRETCH_CYCLES, GAP_CYCLES);
  // ASSERT leaves when the counter reaches STRETCH_CYCLES; the extra cycle
  // covers the edge where rst_s itself drops.
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);

  logic rst_s;

  rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk     (clk),
    .reset   (reset),
    .reset_s (rst_s)
  );

  // ready_in synchronizer, held clear while the internal reset is active
  logic [1:0] rdy_q, rdy_d;
  logic       ready_s;

  always_comb rdy_d = rst_s ? 2'b00 : {rdy_q[0], ready_in};
  assign ready_s = rdy_q[1];

  rst_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d, rel_next;
  logic               done_q, done_d, busy_q, busy_d;

  // Releases go LSB first, so each release is a left shift of the mask.
  assign rel_next = rst_out_q << 1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    if (rst_s || soft_rst_req) begin
      state_d   = ST_ASSERT;
      cnt_d     = '0;
      rst_out_d = '1;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          rst_out_d = '1;
          if (cnt_q == STRETCH_LAST) begin
            state_d = ST_WAIT_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_WAIT_READY: begin
          if (ready_s) begin
            rst_out_d = rel_next;
            state_d   = (rel_next == '0) ? ST_DONE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d     = '0;
            rst_out_d = rel_next;
            if (rel_next == '0) state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DONE: ;
      endcase
    end
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q     <= 2'b00;
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      rdy_q     <= rdy_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign rst_out = rst_out_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ready_in, soft_rst_req;
  logic [3:0] rst_out;
  logic       done, busy;

  logic       reset_b, ready_b, soft_b;
  logic [0:0] rst_out_b;
  logic       done_b, busy_b;

  rst_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .ready_in     (ready_in),
    .soft_rst_req (soft_rst_req),
    .rst_out      (rst_out),
    .done         (done),
    .busy         (busy)
  );

  rst_sequencer #(.NUM_OUT(1), .STRETCH_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .clk          (clk),
    .reset        (reset_b),
    .ready_in     (ready_b),
    .soft_rst_req (soft_b),
    .rst_out      (rst_out_b),
    .done         (done_b),
    .busy         (busy_b)
  );

  typedef struct {
    int         edge_n;
    logic [3:0] rst;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev_rst;
  logic       prev_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int e, input logic [3:0] r, input logic d);
    exp_t x;
    x.edge_n = e;
    x.rst    = r;
    x.dn     = d;
    sb.push_back(x);
  endtask

  // Returns on the falling edge once edge n has happened.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Output-change monitor: every change of rst_out/done must match the
  // next scoreboard entry, including the edge it happens on.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (mon_en && (rst_out !== prev_rst || done !== prev_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_change", {27'b0, done, rst_out}, {27'b0, prev_done, prev_rst});
      end else begin
        e = sb.pop_front();
        chk("change_edge", cyc, e.edge_n);
        chk("change_rst_out", {28'b0, rst_out}, {28'b0, e.rst});
        chk("change_done", {31'b0, done}, {31'b0, e.dn});
      end
    end
    prev_rst  = rst_out;
    prev_done = done;
  end

  initial begin
    int t0;
    int e0;
    reset = 1'b1; ready_in = 1'b1; soft_rst_req = 1'b0;
    reset_b = 1'b1; ready_b = 1'b1; soft_b = 1'b0;
    #2;
    // reset state, before any clock edge
    chk("rst_rst_out", {28'b0, rst_out}, 32'hF);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_b_rst_out", {31'b0, rst_out_b}, 32'h1);
    chk("rst_b_done", {31'b0, done_b}, 32'h0);
    wait_cyc(3);

    // NUM_OUT=1, stretch=1, gap=1: release and done together at edge 4
    reset_b = 1'b0;
    t0 = cyc + 1;
    for (int k = 1; k <= 6; k++) begin
      wait_cyc(t0 + k);
      chk($sformatf("b_rst_out_e%0d", k), {31'b0, rst_out_b}, (k >= 4) ? 32'h0 : 32'h1);
      chk($sformatf("b_done_e%0d", k), {31'b0, done_b}, (k >= 4) ? 32'h1 : 32'h0);
    end

    // default sequence, ready already high
    mon_en = 1'b1;
    reset  = 1'b0;
    t0 = cyc + 1;
    push_exp(t0 + 19, 4'b1110, 1'b0);
    push_exp(t0 + 27, 4'b1100, 1'b0);
    push_exp(t0 + 35, 4'b1000, 1'b0);
    push_exp(t0 + 43, 4'b0000, 1'b1);
    wait_cyc(t0 + 30);
    chk("seq_busy_mid", {31'b0, busy}, 32'h1);
    wait_cyc(t0 + 45);
    chk("seq_busy_done", {31'b0, busy}, 32'h0);
    chk("seq_sb_drained", sb.size(), 0);

    // ready drop in DONE has no effect
    ready_in = 1'b0;
    wait_cyc(cyc + 6);
    chk("rdy_drop_rst_out", {28'b0, rst_out}, 32'h0);
    chk("rdy_drop_done", {31'b0, done}, 32'h1);

    // soft request in DONE: full re-sequence
    ready_in     = 1'b1;
    soft_rst_req = 1'b1;
    e0 = cyc + 1;
    push_exp(e0,      4'b1111, 1'b0);
    push_exp(e0 + 18, 4'b1110, 1'b0);
    push_exp(e0 + 26, 4'b1100, 1'b0);
    push_exp(e0 + 34, 4'b1000, 1'b0);
    push_exp(e0 + 42, 4'b0000, 1'b1);
    wait_cyc(e0);
    soft_rst_req = 1'b0;
    wait_cyc(e0 + 44);
    chk("soft_sb_drained", sb.size(), 0);

    // ready held low until edge 40
    mon_en   = 1'b0;
    reset    = 1'b1;
    ready_in = 1'b0;
    wait_cyc(cyc + 3);
    mon_en = 1'b1;
    reset  = 1'b0;
    t0 = cyc + 1;
    push_exp(t0 + 42, 4'b1110, 1'b0);
    push_exp(t0 + 50, 4'b1100, 1'b0);
    push_exp(t0 + 58, 4'b1000, 1'b0);
    push_exp(t0 + 66, 4'b0000, 1'b1);
    wait_cyc(t0 + 30);
    chk("wait_rdy_busy", {31'b0, busy}, 32'h1);
    wait_cyc(t0 + 39);
    ready_in = 1'b1;
    wait_cyc(t0 + 68);
    chk("wait_rdy_sb_drained", sb.size(), 0);

    // soft request coinciding with reset is dropped; a soft request in
    // ASSERT restarts the stretch count
    mon_en       = 1'b0;
    reset        = 1'b1;
    soft_rst_req = 1'b1;
    wait_cyc(cyc + 3);
    soft_rst_req = 1'b0;
    wait_cyc(cyc + 1);
    mon_en = 1'b1;
    reset  = 1'b0;
    t0 = cyc + 1;
    push_exp(t0 + 28, 4'b1110, 1'b0);
    push_exp(t0 + 36, 4'b1100, 1'b0);
    wait_cyc(t0 + 9);
    soft_rst_req = 1'b1;
    wait_cyc(t0 + 10);
    soft_rst_req = 1'b0;
    wait_cyc(t0 + 40);
    chk("restart_sb_drained", sb.size(), 0);
    chk("mid_release_rst_out", {28'b0, rst_out}, 32'hC);

    // async reset mid-RELEASE, checked before the next edge
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_rst_out", {28'b0, rst_out}, 32'hF);
    chk("async_done", {31'b0, done}, 32'h0);
    chk("async_busy", {31'b0, busy}, 32'h1);
    wait_cyc(cyc + 2);
    reset = 1'b0;
    wait_cyc(cyc + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
